// File: rtl/vga_vram_arbiter.sv
// VGA VRAM arbiter: shares one single-port synchronous VRAM between the
// display fetch path and a CPU port. The display wins while the scan is in
// the visible window, the CPU wins otherwise, and a starvation counter
// forces a CPU slot after STARVE_MAX consecutive refusals. Read returns are
// routed back to their owner through a two-stage tag pipeline that matches
// the command register plus the VRAM read latency.
module vga_vram_arbiter #(
   parameter int unsigned ADDR_W     = 15,
   parameter int unsigned DATA_W     = 12,
   parameter int unsigned STARVE_MAX = 15
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_disp_active,
   input  logic              i_disp_req,
   input  logic [ADDR_W-1:0] i_disp_addr,
   output logic              o_disp_ready,
   output logic              o_disp_rvalid,
   output logic [DATA_W-1:0] o_disp_rdata,
   input  logic              i_cpu_req,
   input  logic              i_cpu_we,
   input  logic [ADDR_W-1:0] i_cpu_addr,
   input  logic [DATA_W-1:0] i_cpu_wdata,
   output logic              o_cpu_ready,
   output logic              o_cpu_rvalid,
   output logic [DATA_W-1:0] o_cpu_rdata,
   output logic              o_ram_en,
   output logic              o_ram_we,
   output logic [ADDR_W-1:0] o_ram_addr,
   output logic [DATA_W-1:0] o_ram_wdata,
   input  logic [DATA_W-1:0] i_ram_rdata
);

   localparam logic [7:0] C_STARVE_MAX = 8'(STARVE_MAX);

   typedef enum logic [1:0] {
      TAG_IDLE,
      TAG_DISP,
      TAG_CPU_RD
   } tag_t;

   logic [7:0] r_starve_cnt;
   tag_t       r_tag1;
   tag_t       r_tag2;
   logic       w_force_cpu;
   logic       w_disp_ready;
   logic       w_cpu_ready;
   logic       w_disp_acc;
   logic       w_cpu_acc;

   // Arbitration: starvation override first, then window-based priority.
   always_comb begin
      w_force_cpu  = (r_starve_cnt == C_STARVE_MAX);
      w_disp_ready = i_rst_n && !w_force_cpu && (i_disp_active || !i_cpu_req);
      w_cpu_ready  = i_rst_n && (w_force_cpu || !i_disp_active || !i_disp_req);
      w_cpu_acc    = i_cpu_req && w_cpu_ready;
      w_disp_acc   = i_disp_req && w_disp_ready && !w_cpu_acc;
   end

   assign o_disp_ready = w_disp_ready;
   assign o_cpu_ready  = w_cpu_ready;

   // Count consecutive CPU refusals, saturating at the forcing threshold.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_starve_cnt <= '0;
      end else if (i_cpu_req && !w_cpu_acc) begin
         if (r_starve_cnt != C_STARVE_MAX) begin
            r_starve_cnt <= r_starve_cnt + 8'd1;
         end
      end else begin
         r_starve_cnt <= '0;
      end
   end

   // Register the winning request as the VRAM command for the next cycle.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         o_ram_en    <= 1'b0;
         o_ram_we    <= 1'b0;
         o_ram_addr  <= '0;
         o_ram_wdata <= '0;
      end else if (w_cpu_acc) begin
         o_ram_en    <= 1'b1;
         o_ram_we    <= i_cpu_we;
         o_ram_addr  <= i_cpu_addr;
         o_ram_wdata <= i_cpu_wdata;
      end else if (w_disp_acc) begin
         o_ram_en    <= 1'b1;
         o_ram_we    <= 1'b0;
         o_ram_addr  <= i_disp_addr;
      end else begin
         o_ram_en    <= 1'b0;
         o_ram_we    <= 1'b0;
      end
   end

   // Owner tags: stage 1 aligns with the command, stage 2 with VRAM data.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_tag1 <= TAG_IDLE;
         r_tag2 <= TAG_IDLE;
      end else begin
         if (w_cpu_acc && !i_cpu_we) begin
            r_tag1 <= TAG_CPU_RD;
         end else if (w_disp_acc) begin
            r_tag1 <= TAG_DISP;
         end else begin
            r_tag1 <= TAG_IDLE;
         end
         r_tag2 <= r_tag1;
      end
   end

   // Return path: pulse the owner's rvalid and capture data; the other holds.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         o_disp_rvalid <= 1'b0;
         o_cpu_rvalid  <= 1'b0;
         o_disp_rdata  <= '0;
         o_cpu_rdata   <= '0;
      end else begin
         o_disp_rvalid <= (r_tag2 == TAG_DISP);
         o_cpu_rvalid  <= (r_tag2 == TAG_CPU_RD);
         if (r_tag2 == TAG_DISP) begin
            o_disp_rdata <= i_ram_rdata;
         end
         if (r_tag2 == TAG_CPU_RD) begin
            o_cpu_rdata <= i_ram_rdata;
         end
      end
   end

endmodule

// File: tb/tb_vga_vram_arbiter.sv
// Bench for vga_vram_arbiter: a VRAM model answers the DUT's commands, and a
// transaction-level reference (winner rule, refusal count, shadow memory and
// a queue of expected returns) predicts every ready, command and return.
module tb_vga_vram_arbiter;

   localparam int AW = 15;
   localparam int DW = 12;
   localparam int SM = 3;

   logic          clk = 1'b0;
   logic          rst_n, disp_active, disp_req, cpu_req, cpu_we;
   logic [AW-1:0] disp_addr, cpu_addr, ram_addr;
   logic [DW-1:0] cpu_wdata, disp_rdata, cpu_rdata, ram_wdata, ram_rdata;
   logic          disp_ready, disp_rvalid, cpu_ready, cpu_rvalid, ram_en, ram_we;

   int n_checks = 0;
   int n_err    = 0;

   always #5 clk = ~clk;

   vga_vram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SM)) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_disp_active(disp_active),
      .i_disp_req(disp_req), .i_disp_addr(disp_addr), .o_disp_ready(disp_ready),
      .o_disp_rvalid(disp_rvalid), .o_disp_rdata(disp_rdata),
      .i_cpu_req(cpu_req), .i_cpu_we(cpu_we), .i_cpu_addr(cpu_addr),
      .i_cpu_wdata(cpu_wdata), .o_cpu_ready(cpu_ready), .o_cpu_rvalid(cpu_rvalid),
      .o_cpu_rdata(cpu_rdata), .o_ram_en(ram_en), .o_ram_we(ram_we),
      .o_ram_addr(ram_addr), .o_ram_wdata(ram_wdata), .i_ram_rdata(ram_rdata)
   );

   // Preset VRAM contents; address 0x0010 holds 0xABC.
   function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
      logic [31:0] t;
      t = 32'(a) * 37 + 5;
      if (a == 15'h0010) return 12'hABC;
      return t[DW-1:0];
   endfunction

   // VRAM model: single port, synchronous read.
   logic [DW-1:0] ram   [0:(1<<AW)-1];
   bit            ram_wr[0:(1<<AW)-1];
   always @(posedge clk) begin
      if (ram_en) begin
         if (ram_we) begin
            ram[ram_addr]    <= ram_wdata;
            ram_wr[ram_addr] <= 1'b1;
         end else begin
            ram_rdata <= ram_wr[ram_addr] ? ram[ram_addr] : init_val(ram_addr);
         end
      end
   end

   // Reference model state
   typedef struct { bit cpu; logic [DW-1:0] data; int due; } ret_t;
   ret_t          q[$];
   logic [DW-1:0] ref_mem[0:(1<<AW)-1];
   bit            ref_wr [0:(1<<AW)-1];
   int            starve = 0;
   int            edge_n = 0;
   bit            e_en, e_we, e_dv, e_cv;
   logic [AW-1:0] e_addr;
   logic [DW-1:0] e_wd, e_drd, e_crd;
   logic          last_dr, last_cr;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (edge %0d)", name, act, exp, edge_n);
      end
   endtask

   function automatic logic [DW-1:0] ref_read(input logic [AW-1:0] a);
      return ref_wr[a] ? ref_mem[a] : init_val(a);
   endfunction

   // Who wins this cycle: 0 nobody, 1 display, 2 CPU.
   function automatic int winner();
      if (!rst_n) return 0;
      if (starve >= SM) return 2;
      if (disp_req && cpu_req) return disp_active ? 1 : 2;
      if (disp_req) return 1;
      if (cpu_req) return 2;
      return 0;
   endfunction

   task automatic set_in(input bit rst, input bit act, input bit dreq, input logic [AW-1:0] da,
                         input bit creq, input bit cwe, input logic [AW-1:0] ca,
                         input logic [DW-1:0] cwd);
      rst_n = rst; disp_active = act; disp_req = dreq; disp_addr = da;
      cpu_req = creq; cpu_we = cwe; cpu_addr = ca; cpu_wdata = cwd;
   endtask

   task automatic check_ready();
      int w;
      w = winner();
      last_dr = disp_ready;
      last_cr = cpu_ready;
      if (!rst_n) begin
         chk("disp_ready_in_reset", disp_ready, 0);
         chk("cpu_ready_in_reset", cpu_ready, 0);
      end else begin
         if (disp_req) chk("disp_ready", disp_ready, (w == 1));
         if (cpu_req)  chk("cpu_ready", cpu_ready, (w == 2));
         if (disp_req && cpu_req) chk("ready_exclusive", disp_ready && cpu_ready, 0);
      end
   endtask

   task automatic finish_cycle();
      int  w;
      bit  acc_d, acc_c;
      w = winner();
      acc_d = disp_req && (w == 1);
      acc_c = cpu_req && (w == 2);
      @(posedge clk);
      edge_n++;
      e_dv = 0; e_cv = 0;
      if (!rst_n) begin
         q.delete();
         starve = 0;
         e_en = 0; e_we = 0; e_addr = '0; e_wd = '0; e_drd = '0; e_crd = '0;
      end else begin
         starve = (cpu_req && !acc_c) ? ((starve + 1 > SM) ? SM : starve + 1) : 0;
         e_en = acc_c || acc_d;
         e_we = acc_c && cpu_we;
         if (acc_c) begin
            e_addr = cpu_addr;
            if (cpu_we) begin
               e_wd = cpu_wdata;
               ref_mem[cpu_addr] = cpu_wdata;
               ref_wr[cpu_addr]  = 1'b1;
            end else begin
               q.push_back('{cpu: 1'b1, data: ref_read(cpu_addr), due: edge_n + 2});
            end
         end else if (acc_d) begin
            e_addr = disp_addr;
            q.push_back('{cpu: 1'b0, data: ref_read(disp_addr), due: edge_n + 2});
         end
         if (q.size() > 0 && q[0].due == edge_n) begin
            ret_t r;
            r = q.pop_front();
            if (r.cpu) begin e_cv = 1; e_crd = r.data; end
            else begin e_dv = 1; e_drd = r.data; end
         end
      end
      #1;
      chk("ram_en", ram_en, e_en);
      if (e_en) begin
         chk("ram_we", ram_we, e_we);
         chk("ram_addr", ram_addr, e_addr);
         if (e_we) chk("ram_wdata", ram_wdata, e_wd);
      end
      chk("disp_rvalid", disp_rvalid, e_dv);
      chk("cpu_rvalid", cpu_rvalid, e_cv);
      chk("disp_rdata", disp_rdata, e_drd);
      chk("cpu_rdata", cpu_rdata, e_crd);
      @(negedge clk);
   endtask

   task automatic run(input bit rst, input bit act, input bit dreq, input logic [AW-1:0] da,
                      input bit creq, input bit cwe, input logic [AW-1:0] ca,
                      input logic [DW-1:0] cwd);
      set_in(rst, act, dreq, da, creq, cwe, ca, cwd);
      #1;
      check_ready();
      finish_cycle();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) run(1, 1, 0, '0, 0, 0, '0, '0);
   endtask

   task automatic do_reset();
      run(0, 0, 0, '0, 0, 0, '0, '0);
   endtask

   typedef struct {
      bit rst; bit act; bit dreq; bit creq;
      bit chk_d; bit exp_d; bit chk_c; bit exp_c; bit exp_en;
   } vec_t;

   initial begin
      vec_t vt[9];
      bit   pat[8];
      set_in(0, 0, 0, '0, 0, 0, '0, '0);
      @(negedge clk);
      do_reset();
      chk("reset_ram_addr", ram_addr, 0);
      chk("reset_ram_wdata", ram_wdata, 0);

      // Single-cycle arbitration table, each row from a freshly reset state.
      vt[0] = '{0, 1, 1, 1, 1, 0, 1, 0, 0};
      vt[1] = '{1, 1, 1, 1, 1, 1, 1, 0, 1};
      vt[2] = '{1, 0, 1, 1, 1, 0, 1, 1, 1};
      vt[3] = '{1, 1, 1, 0, 1, 1, 0, 0, 1};
      vt[4] = '{1, 0, 0, 1, 0, 0, 1, 1, 1};
      vt[5] = '{1, 0, 1, 0, 1, 1, 0, 0, 1};
      vt[6] = '{1, 1, 0, 1, 0, 0, 1, 1, 1};
      vt[7] = '{1, 0, 0, 0, 0, 0, 0, 0, 0};
      vt[8] = '{0, 0, 0, 1, 1, 0, 1, 0, 0};
      for (int i = 0; i < 9; i++) begin
         do_reset();
         set_in(vt[i].rst, vt[i].act, vt[i].dreq, 15'h0020, vt[i].creq, 0, 15'h0021, '0);
         #1;
         if (vt[i].chk_d) chk($sformatf("tbl%0d_disp_ready", i), disp_ready, vt[i].exp_d);
         if (vt[i].chk_c) chk($sformatf("tbl%0d_cpu_ready", i), cpu_ready, vt[i].exp_c);
         check_ready();
         finish_cycle();
         chk($sformatf("tbl%0d_ram_en", i), ram_en, vt[i].exp_en);
      end

      // Display read latency with preset data.
      do_reset();
      run(1, 1, 1, 15'h0010, 0, 0, '0, '0);
      chk("lat_ram_en", ram_en, 1);
      chk("lat_ram_addr", ram_addr, 15'h0010);
      idle(1);
      chk("lat_rvalid_early", disp_rvalid, 0);
      idle(1);
      chk("lat_rvalid", disp_rvalid, 1);
      chk("lat_rdata", disp_rdata, 12'hABC);
      idle(1);
      chk("lat_rvalid_one_cycle", disp_rvalid, 0);

      // Starvation guard with both requesting in the visible window.
      do_reset();
      pat = '{0, 0, 0, 1, 0, 0, 0, 1};
      for (int i = 0; i < 8; i++) begin
         run(1, 1, 1, 15'(40 + i), 1, 0, 15'(60 + i), '0);
         chk($sformatf("starve_grant%0d", i), last_cr, pat[i]);
      end
      idle(3);

      // Blanking: CPU takes every cycle.
      for (int i = 0; i < 4; i++) begin
         run(1, 0, 1, 15'(80 + i), 1, 0, 15'(90 + i), '0);
         chk("blank_disp_ready", last_dr, 0);
         chk("blank_cpu_ready", last_cr, 1);
      end
      idle(3);

      // CPU write then display read of the same word on the next cycle.
      run(1, 0, 0, '0, 1, 1, 15'h0100, 12'h5A5);
      run(1, 1, 1, 15'h0100, 0, 0, '0, '0);
      idle(2);
      chk("raw_rvalid", disp_rvalid, 1);
      chk("raw_rdata", disp_rdata, 12'h5A5);

      // Alternating CPU / display reads.
      for (int i = 0; i < 8; i++) begin
         if (i % 2 == 0) run(1, 1, 0, '0, 1, 0, 15'(200 + i), '0);
         else            run(1, 1, 1, 15'(300 + i), 0, 0, '0, '0);
      end
      idle(3);

      // Reset while a display read is in flight.
      run(1, 1, 1, 15'h0010, 0, 0, '0, '0);
      do_reset();
      chk("rst_ram_en", ram_en, 0);
      chk("rst_ram_addr", ram_addr, 0);
      chk("rst_disp_rdata", disp_rdata, 0);
      for (int i = 0; i < 3; i++) begin
         idle(1);
         chk("rst_no_rvalid", disp_rvalid, 0);
      end

      // Randomized traffic.
      for (int i = 0; i < 1500; i++) begin
         bit rst, act;
         rst = ($urandom_range(63) != 0);
         act = ($urandom_range(3) != 0);
         run(rst, act, $urandom_range(2) != 0, 15'($urandom_range(63)),
             $urandom_range(1) != 0, $urandom_range(4) < 2, 15'($urandom_range(63)),
             12'($urandom));
      end
      idle(4);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule

// File: doc/vga_vram_arbiter.md
VGA_VRAM_ARBITER -- requirements
Module: vga_vram_arbiter

Interface
REQ-001 Parameter ADDR_W, default 15, VRAM word-address width (160x120 words max).
REQ-002 Parameter DATA_W, default 12, VRAM word width (4-bit R, G, B).
REQ-003 Parameter STARVE_MAX, default 15, number of refused CPU cycles before the CPU is forced a slot; legal range 1..255.
REQ-004 Port clk  in  1  single clock; all logic on its rising edge.
REQ-005 Port rst_n  in  1  synchronous, active-low reset.
REQ-006 Port disp_active  in  1  high while the scan is inside the visible window.
REQ-007 Port disp_req / disp_addr  in  1 / ADDR_W  display fetch request and word address.
REQ-008 Port disp_ready  out  1  display request accepted this cycle when disp_req && disp_ready.
REQ-009 Port disp_rvalid / disp_rdata  out  1 / DATA_W  display read return.
REQ-010 Port cpu_req / cpu_we / cpu_addr / cpu_wdata  in  1 / 1 / ADDR_W / DATA_W  CPU access request.
REQ-011 Port cpu_ready  out  1  CPU request accepted this cycle when cpu_req && cpu_ready.
REQ-012 Port cpu_rvalid / cpu_rdata  out  1 / DATA_W  CPU read return; writes produce no return.
REQ-013 Port ram_en / ram_we / ram_addr / ram_wdata  out  1 / 1 / ADDR_W / DATA_W  single-port synchronous VRAM command.
REQ-014 Port ram_rdata  in  DATA_W  VRAM read data, valid the cycle after the edge that samples ram_en && !ram_we.

Function
REQ-015 At most one request SHALL be accepted per cycle; disp_ready and cpu_ready SHALL never both be high while both req inputs are high.
REQ-016 Priority: disp_active=1 -> display wins; disp_active=0 -> CPU wins.
REQ-017 Starvation guard: starve_cnt SHALL increment each cycle cpu_req=1 and not accepted, clear on CPU acceptance or cpu_req=0, and saturate at STARVE_MAX.
REQ-018 When starve_cnt==STARVE_MAX the CPU SHALL win the next arbitration regardless of disp_active; disp_ready=0 that cycle.
REQ-019 ready outputs SHALL be combinational from req inputs, disp_active and starve_cnt; ready may be high with req low.
REQ-020 On acceptance edge k the block SHALL register ram_en=1, ram_we, ram_addr, ram_wdata from the winner; ram_en=0 in any cycle after an edge with no acceptance.
REQ-021 A 2-stage owner tag pipeline (IDLE/DISP/CPU_RD) SHALL track each read; writes load tag IDLE.
REQ-022 Read latency: rvalid SHALL be high for exactly one cycle, following edge k+2, with rdata registered from ram_rdata; owner selected by tag.
REQ-023 Back-to-back acceptances SHALL sustain one access per cycle, returns in acceptance order, none dropped.
REQ-024 Only the owning rvalid SHALL assert; rdata of the non-owner SHALL hold its previous value.
REQ-025 CPU write accepted at edge k: ram_we=1 in cycle after k; VRAM content visible to a read accepted at edge k+1 or later.
REQ-026 disp_active changing in the same cycle as both requests: the new value governs that cycle's arbitration.

Reset
REQ-027 rst_n=0 sampled on an edge SHALL clear ram_en, ram_we, disp_rvalid, cpu_rvalid, starve_cnt and both tag stages; ram_addr, ram_wdata, rdata outputs SHALL reset to 0.
REQ-028 While rst_n=0, disp_ready and cpu_ready SHALL be 0.
REQ-029 Reset mid-operation SHALL cancel in-flight reads: no rvalid after the reset edge, including after rst_n returns high.

Verification
REQ-030 Reset then disp_req=1, addr=0x0010, disp_active=1, RAM[0x0010]=0xABC -> ram_en edge k+1, disp_rvalid=1 with 0xABC after edge k+2.
REQ-031 disp_active=1, both requesting continuously, STARVE_MAX=3 -> 3 display grants, then one CPU grant, repeating; starve_cnt clears.
REQ-032 disp_active=0, both requesting -> CPU accepted every cycle, disp_ready=0 throughout.
REQ-033 CPU write 0x5A5 to 0x0100 at edge k, display read 0x0100 at edge k+1 -> disp_rdata=0x5A5.
REQ-034 Alternating CPU read / display read every cycle -> returns in order, each rvalid one cycle, correct owner and data.
REQ-035 Display read accepted, rst_n=0 at edge k+1 -> no disp_rvalid at k+2 or later; all outputs at reset values.
